// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns single-beat local commands into AXI-Lite write/read
// transactions and returns one response per command. Optional watchdog: AXI_LITE_CMD_MASTER_TIMEOUT_EN.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      aclk,
  input  logic                      areset,
  // Local command interface
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // Local response interface
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_write,
  // AXI4-Lite write address channel
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  // AXI4-Lite write data channel
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  // AXI4-Lite write response channel
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  // AXI4-Lite read address channel
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  // AXI4-Lite read data channel
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_e;

  localparam logic [1:0] RespTimeout = 2'b11;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      write_q, write_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      rsp_write_q, rsp_write_d;
  logic                      timeout_hit;
  logic                      aw_now, w_now;

  // Every AXI control output is a pure function of state so it drops the
  // instant reset is asserted, with no registered lag.
  assign cmd_ready = (state_q == IDLE);
  assign awvalid   = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid    = (state_q == WR_REQ) && !w_done_q;
  assign bready    = (state_q == WR_RESP);
  assign arvalid   = (state_q == RD_REQ);
  assign rready    = (state_q == RD_DATA);
  assign rsp_valid = (state_q == RSP);

  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_write = rsp_write_q;

  assign aw_now = aw_done_q || (awvalid && awready);
  assign w_now  = w_done_q  || (wvalid  && wready);

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  localparam int TimerW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TimerW-1:0] timer_q, timer_d;
  logic              waiting;

  assign waiting     = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                       (state_q == RD_REQ) || (state_q == RD_DATA);
  assign timeout_hit = waiting && (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

  // The counter restarts on every state change, so each wait state gets a
  // fresh budget; it only advances while a handshake is outstanding.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (waiting) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    write_d     = write_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_write_d = rsp_write_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? WR_REQ : RD_REQ;
        end
      end

      // AW and W complete independently; a finished channel stays finished
      // until the other catches up.
      WR_REQ: begin
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end else if (timeout_hit) begin
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          rsp_resp_d  = RespTimeout;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          state_d     = RSP;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end

      WR_RESP: begin
        if (bvalid) begin
          rsp_resp_d  = bresp;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          state_d     = RSP;
        end else if (timeout_hit) begin
          rsp_resp_d  = RespTimeout;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          state_d     = RSP;
        end
      end

      RD_REQ: begin
        if (arready) begin
          state_d = RD_DATA;
        end else if (timeout_hit) begin
          rsp_resp_d  = RespTimeout;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b0;
          state_d     = RSP;
        end
      end

      RD_DATA: begin
        if (rvalid) begin
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
          rsp_write_d = 1'b0;
          state_d     = RSP;
        end else if (timeout_hit) begin
          rsp_resp_d  = RespTimeout;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b0;
          state_d     = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_write_q <= rsp_write_d;
    end
  end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- AXI4-Lite initiator that converts single-beat commands from local control logic into AXI-Lite write or read transactions.
- Drives slaves such as the buzzer register interface (4-bit address, 32-bit data) without a processor.
- Accepts one command at a time and returns one response per command: read data plus the BRESP or RRESP code.
- Sits between a local sequencer (for example a boot-time register loader) and an AXI-Lite interconnect or slave port.

Parameters:
- ADDR_WIDTH, 4: width of cmd_addr, awaddr and araddr.
- DATA_WIDTH, 32: width of the data buses; must be 32 or 64.
- TIMEOUT_CYCLES, 1024: watchdog limit; used only with AXI_LITE_CMD_MASTER_TIMEOUT_EN.

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP code (11 = timeout, option only).
- rsp_write  out  1  echo of cmd_write.
- awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: AXI4-Lite master-side channels, widths per parameters.
- awprot and arprot are tied to 3'b000.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Values while areset is high: state=IDLE, cmd_ready=1, rsp_valid=0, awvalid=wvalid=bready=arvalid=rready=0, rsp_rdata=0, rsp_resp=0, rsp_write=0, all address and data outputs 0.
- IDLE:
  - cmd_ready=1.
  - On command accept, register addr, wdata, wstrb and write into holding registers and drop cmd_ready.
  - Write commands go to WR_REQ; read commands go to RD_REQ. Next-cycle outputs follow the target state.
- WR_REQ:
  - Assert awvalid and wvalid together in the first cycle.
  - Each valid drops independently the cycle after its own handshake (awvalid&awready, wvalid&wready).
  - Once both handshakes have completed, in any order or in the same cycle, go to WR_RESP.
  - A valid is never withdrawn before its handshake, and its payload is held stable.
- WR_RESP:
  - bready=1.
  - On bvalid, capture bresp into rsp_resp, set rsp_rdata=0 and rsp_write=1, then go to RSP.
- RD_REQ:
  - arvalid=1 until arready; then go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid, capture rdata and rresp, set rsp_write=0, then go to RSP.
- RSP:
  - rsp_valid=1, with response fields held stable.
  - On rsp_ready, go to IDLE; cmd_ready=1 in the following cycle, so there is no command/response overlap.
- Minimum latency, with a slave ready immediately:
  - Write: accept at cycle 0, AW/W handshake at cycle 1, B at cycle 2, rsp_valid at cycle 3.
  - Read: rsp_valid at cycle 3.
- A cmd_valid arriving while busy is ignored; cmd_ready=0 in every state except IDLE.
- areset asserted mid-transaction aborts immediately to reset values; the slave is expected to be reset on the same domain.
- Responses SLVERR and DECERR are passed through unchanged; the block does not retry.

Optional Feature:
- Macro: AXI_LITE_CMD_MASTER_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on entry to WR_REQ, WR_RESP, RD_REQ and RD_DATA, and increments each cycle in those states.
  - When the count reaches TIMEOUT_CYCLES-1 without the awaited handshake, all AXI valids and readies drop and the FSM goes to RSP with rsp_resp=2'b11 and rsp_rdata=0.
- When undefined: no counter exists, and the FSM waits indefinitely in every state.

Test Plan:
- Write with the slave always ready: cmd addr=0x4, wdata=0x0000_00FF, wstrb=0xF -> awaddr=0x4, wdata=0xFF with awvalid and wvalid in the same cycle; rsp_valid at cycle 3; rsp_resp=00, rsp_write=1.
- Skewed ready: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 0x4 stable until its handshake; exactly one B accepted.
- Read addr=0x8 with the slave returning rdata=0x1234_5678 and rresp=00 after 2 cycles -> rsp_rdata=0x12345678, rsp_write=0.
- Backpressure: rsp_ready held low for 5 cycles -> rsp_valid and fields stable; cmd_ready stays 0; a second cmd_valid during this time is not accepted.
- Error plus reset: slave returns bresp=10 -> rsp_resp=10. Separately, areset pulsed during WR_RESP -> all outputs return to their reset values in the same cycle, and cmd_ready=1 after release.
- Timeout (macro defined, TIMEOUT_CYCLES=16), arready never asserted -> arvalid drops after 16 cycles; rsp_resp=11, rsp_rdata=0.
